// File: rtl/seq_arith_pkg.sv
// Shared constants and types for the sequential (slice-serial) arithmetic units.
//   SLICE      : bits processed per cycle
//   WIDTH      : full operand width
//   NUM_SLICES : slices per operation
//   state_e    : control FSM states
//   cnt_t      : slice index type
package seq_arith_pkg;

    localparam int unsigned SLICE      = 16;
    localparam int unsigned WIDTH      = 64;
    localparam int unsigned NUM_SLICES = WIDTH / SLICE;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef logic [1:0] cnt_t;

endpackage

// File: rtl/seq_subtractor_64bit_if.sv
// Start/done operation-unit bus for seq_subtractor_64bit.
//   master : control side (drives start, in1, in2, b_in; observes results)
//   slave  : subtractor side
// Optional macro SUB_OVF_EN adds the signed-overflow signal ovf.
interface seq_subtractor_64bit_if;
    import seq_arith_pkg::*;

    logic             start;
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic             b_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             b_out;
`ifdef SUB_OVF_EN
    logic             ovf;

    modport master (
        output start, in1, in2, b_in,
        input  busy, done, diff, b_out, ovf
    );

    modport slave (
        input  start, in1, in2, b_in,
        output busy, done, diff, b_out, ovf
    );
`else
    modport master (
        output start, in1, in2, b_in,
        input  busy, done, diff, b_out
    );

    modport slave (
        input  start, in1, in2, b_in,
        output busy, done, diff, b_out
    );
`endif

endinterface

// File: rtl/cla_16bit_slice.sv
// Combinational 16-bit carry-lookahead adder slice.
//   a_i, b_i : addends
//   c_i      : carry in
//   s_o      : sum
//   c_o      : carry out
// Two-level lookahead: 4-bit groups produce group generate/propagate, group carries are
// resolved in one lookahead level, then bit carries inside each group come from the group
// carry-in.
module cla_16bit_slice (
    input  logic [15:0] a_i,
    input  logic [15:0] b_i,
    input  logic        c_i,
    output logic [15:0] s_o,
    output logic        c_o
);

    logic [15:0] g;
    logic [15:0] p;
    logic [15:0] c;
    logic [3:0]  gg;
    logic [3:0]  gp;
    logic [4:0]  gc;

    assign g = a_i & b_i;
    assign p = a_i ^ b_i;

    always_comb begin
        gg = '0;
        gp = '0;
        for (int j = 0; j < 4; j++) begin
            gg[j] = g[4*j+3]
                  | (p[4*j+3] & g[4*j+2])
                  | (p[4*j+3] & p[4*j+2] & g[4*j+1])
                  | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
            gp[j] = &p[4*j +: 4];
        end
    end

    assign gc[0] = c_i;
    assign gc[1] = gg[0] | (gp[0] & c_i);
    assign gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & c_i);
    assign gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
                 | (gp[2] & gp[1] & gp[0] & c_i);
    assign gc[4] = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
                 | (gp[3] & gp[2] & gp[1] & gg[0])
                 | (gp[3] & gp[2] & gp[1] & gp[0] & c_i);

    always_comb begin
        c = '0;
        for (int j = 0; j < 4; j++) begin
            c[4*j]   = gc[j];
            c[4*j+1] = g[4*j] | (p[4*j] & gc[j]);
            c[4*j+2] = g[4*j+1] | (p[4*j+1] & g[4*j]) | (p[4*j+1] & p[4*j] & gc[j]);
            c[4*j+3] = g[4*j+2] | (p[4*j+2] & g[4*j+1])
                     | (p[4*j+2] & p[4*j+1] & g[4*j])
                     | (p[4*j+2] & p[4*j+1] & p[4*j] & gc[j]);
        end
    end

    assign s_o = p ^ c;
    assign c_o = gc[4];

endmodule

// File: rtl/seq_subtractor_64bit.sv
// Multi-cycle 64-bit subtractor: diff = in1 - in2 - b_in, computed as in1 + ~in2 + ~b_in
// one 16-bit slice per cycle (LSB first) through a single CLA slice with a registered carry.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : start/done operation bus (slave side): start, in1, in2, b_in in;
//           busy, done, diff, b_out (and ovf) out
// Optional macro SUB_OVF_EN: adds the registered signed-overflow output ovf.
// Latency 4 cycles from accepted start to done; a start during DONE is accepted back-to-back.
module seq_subtractor_64bit
    import seq_arith_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    seq_subtractor_64bit_if.slave bus
);

    state_e           state_q, state_d;
    cnt_t             cnt_q, cnt_d;
    logic [WIDTH-1:0] in1_q, in1_d;
    logic [WIDTH-1:0] in2_q, in2_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             b_out_q, b_out_d;
`ifdef SUB_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    logic [SLICE-1:0] a_slice;
    logic [SLICE-1:0] b_slice;
    logic [SLICE-1:0] sum;
    logic             cout;

    // Slice cnt of both operands; subtrahend inverted for two's-complement subtraction.
    assign a_slice = in1_q[{cnt_q, 4'b0000} +: SLICE];
    assign b_slice = ~in2_q[{cnt_q, 4'b0000} +: SLICE];

    cla_16bit_slice u_cla (
        .a_i (a_slice),
        .b_i (b_slice),
        .c_i (carry_q),
        .s_o (sum),
        .c_o (cout)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        in1_d   = in1_q;
        in2_d   = in2_q;
        carry_d = carry_q;
        diff_d  = diff_q;
        b_out_d = b_out_q;
`ifdef SUB_OVF_EN
        ovf_d   = ovf_q;
`endif
        unique case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    in1_d   = bus.in1;
                    in2_d   = bus.in2;
                    carry_d = ~bus.b_in;
                    cnt_d   = '0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                diff_d[{cnt_q, 4'b0000} +: SLICE] = sum;
                carry_d = cout;
                cnt_d   = cnt_q + 2'd1;
                if (cnt_q == cnt_t'(NUM_SLICES - 1)) begin
                    b_out_d = ~cout;
`ifdef SUB_OVF_EN
                    // sum[15] is diff[63] being written this cycle.
                    ovf_d   = (in1_q[WIDTH-1] ^ in2_q[WIDTH-1]) & (in1_q[WIDTH-1] ^ sum[SLICE-1]);
`endif
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            in1_q   <= '0;
            in2_q   <= '0;
            carry_q <= 1'b0;
            diff_q  <= '0;
            b_out_q <= 1'b0;
`ifdef SUB_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            in1_q   <= in1_d;
            in2_q   <= in2_d;
            carry_q <= carry_d;
            diff_q  <= diff_d;
            b_out_q <= b_out_d;
`ifdef SUB_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign bus.busy  = (state_q == RUN);
    assign bus.done  = (state_q == DONE);
    assign bus.diff  = diff_q;
    assign bus.b_out = b_out_q;
`ifdef SUB_OVF_EN
    assign bus.ovf   = ovf_q;
`endif

endmodule

// File: tb/tb_seq_subtractor_64bit.sv
// Directed self-checking bench for seq_subtractor_64bit.
module tb_seq_subtractor_64bit;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    seq_subtractor_64bit_if bus ();

    seq_subtractor_64bit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic issue(input logic [63:0] a, input logic [63:0] b, input logic bin);
        bus.start = 1'b1;
        bus.in1   = a;
        bus.in2   = b;
        bus.b_in  = bin;
    endtask

    // Returns number of rising edges waited until done is seen (10 if it never appears).
    task automatic wait_done(output int lat);
        lat = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            lat++;
            if (bus.done) break;
        end
    endtask

    task automatic check_ovf(input string tag, input logic exp_ovf);
`ifdef SUB_OVF_EN
        check_eq(tag, bus.ovf, exp_ovf);
`else
        if (exp_ovf === 1'bx) $display("note: %s", tag);
`endif
    endtask

    // Called with start already driven; next rising edge is E0.
    task automatic finish_op(input string tag, input logic [63:0] exp_diff, input logic exp_bout,
                             input logic exp_ovf);
        int lat;
        @(posedge clk);
        #1;
        check_eq({tag, "_busy"}, bus.busy, 1'b1);
        @(negedge clk);
        // Scramble inputs after acceptance: must not affect the result.
        bus.start = 1'b0;
        bus.in1   = ~bus.in1;
        bus.in2   = ~bus.in2;
        bus.b_in  = ~bus.b_in;
        wait_done(lat);
        check_eq({tag, "_lat"}, lat, 4);
        check_eq({tag, "_diff"}, bus.diff, exp_diff);
        check_eq({tag, "_bout"}, bus.b_out, exp_bout);
        check_ovf({tag, "_ovf"}, exp_ovf);
        @(posedge clk);
        #1;
        check_eq({tag, "_done_fall"}, bus.done, 1'b0);
        check_eq({tag, "_diff_hold"}, bus.diff, exp_diff);
    endtask

    task automatic run_op(input string tag, input logic [63:0] a, input logic [63:0] b,
                          input logic bin, input logic [63:0] exp_diff, input logic exp_bout,
                          input logic exp_ovf);
        @(negedge clk);
        issue(a, b, bin);
        finish_op(tag, exp_diff, exp_bout, exp_ovf);
    endtask

    initial begin
        int lat;
        int done_seen;
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.in1   = '0;
        bus.in2   = '0;
        bus.b_in  = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_busy", bus.busy, 1'b0);
        check_eq("rst_done", bus.done, 1'b0);
        check_eq("rst_diff", bus.diff, 64'h0);
        check_eq("rst_bout", bus.b_out, 1'b0);
        check_ovf("rst_ovf", 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("sub_5_3", 64'd5, 64'd3, 1'b0, 64'd2, 1'b0, 1'b0);
        run_op("sub_0_1", 64'd0, 64'd1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0);
        run_op("ripple", 64'h0000_0001_0000_0000, 64'd1, 1'b0, 64'h0000_0000_FFFF_FFFF, 1'b0,
               1'b0);
        run_op("ovf_min", 64'h8000_0000_0000_0000, 64'd1, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0,
               1'b1);

        // Back-to-back: second start raised during DONE.
        @(negedge clk);
        issue(64'd10, 64'd3, 1'b1);
        @(posedge clk);
        #1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(lat);
        check_eq("b2b1_lat", lat, 4);
        check_eq("b2b1_diff", bus.diff, 64'd6);
        check_eq("b2b1_bout", bus.b_out, 1'b0);
        @(negedge clk);
        issue(64'd3245, 64'd16785, 1'b0);
        @(posedge clk);
        #1;
        check_eq("b2b2_busy", bus.busy, 1'b1);
        check_eq("b2b2_done_fall", bus.done, 1'b0);
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(lat);
        check_eq("b2b2_spacing", lat + 1, 5);
        check_eq("b2b2_diff", bus.diff, 64'hFFFF_FFFF_FFFF_CB1C);
        check_eq("b2b2_bout", bus.b_out, 1'b1);
        @(posedge clk);
        #1;

        // Start pulsed during RUN with other operands must be ignored.
        @(negedge clk);
        issue(64'd100, 64'd1, 1'b0);
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        issue(64'd7, 64'd9, 1'b1);
        @(posedge clk);
        #1;
        check_eq("run_start_busy", bus.busy, 1'b1);
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(lat);
        check_eq("run_start_lat", lat, 2);
        check_eq("run_start_diff", bus.diff, 64'd99);
        check_eq("run_start_bout", bus.b_out, 1'b0);
        @(posedge clk);
        #1;
        check_eq("run_start_idle", bus.busy, 1'b0);

        // Reset in the middle of a fresh operation (just after E2).
        @(negedge clk);
        issue(64'h1234_5678_9ABC_DEF0, 64'd1, 1'b0);
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("midrst_busy", bus.busy, 1'b0);
        check_eq("midrst_done", bus.done, 1'b0);
        check_eq("midrst_diff", bus.diff, 64'h0);
        check_eq("midrst_bout", bus.b_out, 1'b0);
        check_ovf("midrst_ovf", 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n     = 1'b1;
        done_seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (bus.done) done_seen++;
        end
        check_eq("midrst_no_done", done_seen, 0);
        check_eq("midrst_idle", bus.busy, 1'b0);

        // Start accepted on the first rising edge after reset release.
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        issue(64'd7, 64'd9, 1'b1);
        finish_op("post_rst", 64'hFFFF_FFFF_FFFF_FFFD, 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
